interval_timer: RTL and testbench
=================================

// Module: interval_timer
//
// PURPOSE
//  Parametrised successor to the one-shot timeout counter. Adds a clock
//  prescaler, one-shot or periodic (auto-reload) mode, pause and abort.
//  Also gives a one-cycle expiry strobe, which a "still busy" level cannot.
//  Sits beside protocol FSMs and peripheral drivers as a watchdog, retry or
//  tick source.
//
// PARAMETERS
//  W  8  width of count, value and reload registers
//  P  4  width of prescale field; tick period = prescale+1 clocks
//
// PORTS
//  clock     in   1  single system clock, all state on rising edge
//  reset     in   1  synchronous, active-high reset
//  value     in   W  period in ticks, sampled on put
//  prescale  in   P  tick divider, sampled on put
//  periodic  in   1  mode, sampled on put: 0 one-shot, 1 auto-reload
//  put       in   1  load/start strobe
//  stop      in   1  abort strobe
//  enable    in   1  1 run, 0 pause (freeze count and divider)
//  count     out  W  current remaining ticks (register)
//  full      out  1  count != 0 (timer armed)
//  expire    out  1  one-cycle expiry strobe (register)
//
// BEHAVIOUR
//  - Reset: count, reload, mode, psc, div and expire all 0; full=0.
//  - States: IDLE (count==0), RUN (count>0, enable=1), PAUSE (count>0, enable=0).
//  - Priority per edge: reset > put > stop > tick.
//  - put: count<=value; reload<=value; psc<=prescale; mode<=periodic;
//    div<=0; expire<=0.
//    - put with value==0 leaves the block IDLE and raises no expire.
//  - stop without put: count<=0; div<=0; expire<=0. Silent abort, no strobe.
//  - Divider: only while count>0 and enable=1.
//    - div==psc: tick=1 and div<=0.
//    - otherwise div<=div+1.
//    - enable=0 holds div and count unchanged.
//  - On tick:
//    - count>1: count<=count-1.
//    - count==1: expire<=1 for exactly one cycle, then:
//      - mode=1: count<=reload;
//      - mode=0: count<=0.
//  - expire<=0 on every edge that is not an expiring tick.
//  - Latency, with put at edge k and no pause:
//    - expire is high in the cycle after edge k+value*(psc+1).
//    - In one-shot mode, full drops at that same edge.
//    - In periodic mode, full stays 1 and expire repeats every
//      value*(psc+1) clocks.
//  - Reload: put during RUN restarts cleanly. If it lands on the expiring
//    edge, put wins and there is no expire. reload is only changed by put.
//  - Wrap: count never underflows. Max period is (2^W-1)*2^P clocks.
//  - Reset mid-run: all outputs 0 on the next cycle. The pending expiry
//    is lost.
//  - IDLE: ignores enable and stop; count, full and expire stay 0.
//
// TESTING
//  1 W=8, prescale=0, periodic=0, put value=3 -> count 3,2,1,0 on
//    successive edges; expire high 1 cycle after 3rd edge; full low
//    from then on.
//  2 periodic=1, value=4, prescale=1 -> expire 1-cycle pulse every 8 clocks
//    for >=4 periods; full stays 1; count cycles 4..1.
//  3 one-shot value=6, prescale=0, enable=0 for 5 cycles after 2nd tick ->
//    count held at 4; expire 5 cycles later than in case 1 timing.
//  4 put value=5 on the exact edge where count==1 -> no expire pulse;
//    count=5 next cycle.
//  5 stop during periodic run -> count=0, full=0, no expire. Then put
//    value=0 -> stays IDLE, no expire.
//  6 reset asserted mid-run (count=200, value=255) -> count, full and
//    expire 0 next cycle. Re-put 255, prescale=0 -> expire after 255 clocks.

Source files
------------

// File: rtl/interval_timer_if.sv
// rtl/interval_timer_if.sv - control/status bundle for the interval timer
interface interval_timer_if #(
  parameter int W = 8,
  parameter int P = 4
) ();
  logic [W-1:0] value;
  logic [P-1:0] prescale;
  logic         periodic;
  logic         put;
  logic         stop;
  logic         enable;
  logic [W-1:0] count;
  logic         full;
  logic         expire;

  modport master (
    output value, prescale, periodic, put, stop, enable,
    input  count, full, expire
  );

  modport slave (
    input  value, prescale, periodic, put, stop, enable,
    output count, full, expire
  );
endinterface

// File: rtl/interval_timer.sv
// rtl/interval_timer.sv - prescaled one-shot/periodic interval timer with expiry strobe
module interval_timer #(
  parameter int W = 8,
  parameter int P = 4
) (
  input  logic              clock,
  input  logic              reset,
  interval_timer_if.slave   tif
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_e;

  state_e       state;
  logic [W-1:0] count_q, count_d;
  logic [W-1:0] reload_q, reload_d;
  logic [P-1:0] psc_q, psc_d;
  logic [P-1:0] div_q, div_d;
  logic         mode_q, mode_d;
  logic         expire_q, expire_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q  <= '0;
      reload_q <= '0;
      psc_q    <= '0;
      div_q    <= '0;
      mode_q   <= 1'b0;
      expire_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
      psc_q    <= psc_d;
      div_q    <= div_d;
      mode_q   <= mode_d;
      expire_q <= expire_d;
    end
  end

  always_comb begin
    state    = IDLE;
    count_d  = count_q;
    reload_d = reload_q;
    psc_d    = psc_q;
    div_d    = div_q;
    mode_d   = mode_q;
    expire_d = 1'b0;

    if (count_q != '0) begin
      state = tif.enable ? RUN : PAUSE;
    end

    if (tif.put) begin
      count_d  = tif.value;
      reload_d = tif.value;
      psc_d    = tif.prescale;
      mode_d   = tif.periodic;
      div_d    = '0;
    end else if (tif.stop) begin
      count_d = '0;
      div_d   = '0;
    end else if (state == RUN) begin
      // A tick fires on the clock where the divider has reached the prescale value.
      if (div_q == psc_q) begin
        div_d = '0;
        if (count_q == W'(1)) begin
          expire_d = 1'b1;
          count_d  = mode_q ? reload_q : '0;
        end else begin
          count_d = count_q - W'(1);
        end
      end else begin
        div_d = div_q + P'(1);
      end
    end
  end

  assign tif.count  = count_q;
  assign tif.full   = (count_q != '0);
  assign tif.expire = expire_q;

endmodule

// File: tb/tb_interval_timer.sv
// tb/tb_interval_timer.sv - scoreboard bench for interval_timer
module tb_interval_timer;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   exp_q[$];
  int   k;

  interval_timer_if #(.W(8), .P(4)) tif ();

  interval_timer #(.W(8), .P(4)) dut (
    .clock (clock),
    .reset (reset),
    .tif   (tif)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input int v, input int ps, input bit per, output int edge_k);
    tif.value    = 8'(v);
    tif.prescale = 4'(ps);
    tif.periodic = per;
    tif.put      = 1'b1;
    step();
    edge_k  = cyc;
    tif.put = 1'b0;
  endtask

  // Each expire cycle must match the edge index queued by the stimulus.
  initial begin
    forever begin
      @(negedge clock);
      if (tif.expire === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_expire", cyc, -1);
        end else begin
          check("expire_edge", cyc, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    tif.value = '0; tif.prescale = '0; tif.periodic = 1'b0;
    tif.put = 1'b0; tif.stop = 1'b0; tif.enable = 1'b1;
    reset = 1'b1;
    step(); step();
    check("rst_count", int'(tif.count), 0);
    check("rst_full", int'(tif.full), 0);
    check("rst_expire", int'(tif.expire), 0);
    reset = 1'b0;
    step();

    // one-shot, value 3, no prescale
    load(3, 0, 1'b0, k);
    exp_q.push_back(k + 3);
    check("t1_count_load", int'(tif.count), 3);
    for (int c = 2; c >= 0; c--) begin
      step();
      check("t1_count", int'(tif.count), c);
    end
    check("t1_full_after", int'(tif.full), 0);
    step(); step();
    check("t1_full_idle", int'(tif.full), 0);

    // periodic, value 4, prescale 1 -> expiry every 8 clocks
    load(4, 1, 1'b1, k);
    for (int j = 1; j <= 4; j++) exp_q.push_back(k + 8 * j);
    for (int j = 1; j <= 32; j++) begin
      step();
      check("t2_count", int'(tif.count), 4 - ((j / 2) % 4));
      check("t2_full", int'(tif.full), 1);
    end

    // abort mid-period, then zero-length load
    tif.stop = 1'b1;
    step();
    tif.stop = 1'b0;
    check("t5_stop_count", int'(tif.count), 0);
    check("t5_stop_full", int'(tif.full), 0);
    step(); step();
    load(0, 0, 1'b0, k);
    check("t5_zero_count", int'(tif.count), 0);
    check("t5_zero_full", int'(tif.full), 0);
    repeat (5) step();

    // pause for 5 cycles after the 2nd tick
    load(6, 0, 1'b0, k);
    exp_q.push_back(k + 11);
    step();
    check("t3_count_t1", int'(tif.count), 5);
    step();
    check("t3_count_t2", int'(tif.count), 4);
    tif.enable = 1'b0;
    repeat (5) begin
      step();
      check("t3_paused", int'(tif.count), 4);
    end
    tif.enable = 1'b1;
    for (int c = 3; c >= 0; c--) begin
      step();
      check("t3_count", int'(tif.count), c);
    end
    step();

    // reload exactly on the expiring edge suppresses the strobe
    load(3, 0, 1'b0, k);
    step(); step();
    check("t4_count_one", int'(tif.count), 1);
    load(5, 0, 1'b0, k);
    exp_q.push_back(k + 5);
    check("t4_reload", int'(tif.count), 5);
    repeat (6) step();
    check("t4_done", int'(tif.count), 0);

    // reset mid-run, then a full-range period
    load(255, 0, 1'b0, k);
    repeat (55) step();
    check("t6_count_200", int'(tif.count), 200);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_rst_count", int'(tif.count), 0);
    check("t6_rst_full", int'(tif.full), 0);
    check("t6_rst_expire", int'(tif.expire), 0);
    load(255, 0, 1'b0, k);
    exp_q.push_back(k + 255);
    check("t6_load", int'(tif.count), 255);
    repeat (254) step();
    check("t6_count_one", int'(tif.count), 1);
    check("t6_full_one", int'(tif.full), 1);
    repeat (2) step();
    check("t6_count_end", int'(tif.count), 0);
    check("t6_full_end", int'(tif.full), 0);

    repeat (3) step();
    check("missing_expires", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
